fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 43 ++++
 rtl/ifid_reg.sv | 52 +++++
 rtl/fetch_stage.sv | 113 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the fetch stage
// Purpose : fetch FSM state enum, word width, NOP encoding and PC increment helper.
// Ports   : none (package).
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Wraps modulo 2^32 by construction (0xFFFFFFFC + 4 = 0).
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - control, instruction memory and IF/ID bundle of the fetch stage
// Purpose : groups every fetch_stage signal except clk/rst.
// Ports   : start, stall, redirect, redirect_pc, imem_inst  (master -> slave)
//           imem_pc, ifid_valid, ifid_inst, ifid_pc4, halted (slave -> master)
//           fetch_count, stall_count                          (slave -> master, FETCH_PERF_EN only)
// Macro   : FETCH_PERF_EN adds the performance counter signals.
interface fetch_stage_if;
   import cpu_pkg::*;

   logic            start;
   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] imem_pc;
   logic [XLEN-1:0] imem_inst;
   logic            ifid_valid;
   logic [XLEN-1:0] ifid_inst;
   logic [XLEN-1:0] ifid_pc4;
   logic            halted;
`ifdef FETCH_PERF_EN
   logic [XLEN-1:0] fetch_count;
   logic [XLEN-1:0] stall_count;

   modport master (
      output start, stall, redirect, redirect_pc, imem_inst,
      input  imem_pc, ifid_valid, ifid_inst, ifid_pc4, halted, fetch_count, stall_count
   );
   modport slave (
      input  start, stall, redirect, redirect_pc, imem_inst,
      output imem_pc, ifid_valid, ifid_inst, ifid_pc4, halted, fetch_count, stall_count
   );
`else
   modport master (
      output start, stall, redirect, redirect_pc, imem_inst,
      input  imem_pc, ifid_valid, ifid_inst, ifid_pc4, halted
   );
   modport slave (
      input  start, stall, redirect, redirect_pc, imem_inst,
      output imem_pc, ifid_valid, ifid_inst, ifid_pc4, halted
   );
`endif

endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with flush and hold
// Purpose : holds the fetched instruction and its PC+4 for decode.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           i_flush         kill entry: valid=0, inst=NOP (wins over hold)
//           i_hold          keep current contents
//           i_load          capture i_inst/i_pc4 as a valid entry
//           i_inst, i_pc4   incoming instruction and PC+4
//           o_valid, o_inst, o_pc4  registered IF/ID contents
module ifid_reg
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_flush,
   input  logic            i_hold,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_inst,
   input  logic [XLEN-1:0] i_pc4,
   output logic            o_valid,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_pc4
);

   logic            r_valid;
   logic [XLEN-1:0] r_inst;
   logic [XLEN-1:0] r_pc4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_inst  <= NOP;
         r_pc4   <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_inst  <= NOP;
      end else if (!i_hold) begin
         if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc4   <= i_pc4;
         end else begin
            // Neither hold nor load: insert a bubble, keep the stale data.
            r_valid <= 1'b0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_inst  = r_inst;
   assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, IDLE/RUN/HALT FSM, IF/ID register
// Purpose : fetches one word per cycle from RESET_PC after start, honours stall and
//           redirect, halts after issuing PC_LAST until redirected.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  fetch_stage_if.slave (start/stall/redirect/redirect_pc/imem_inst in,
//                imem_pc/ifid_valid/ifid_inst/ifid_pc4/halted out)
// Macro   : FETCH_PERF_EN adds saturating fetch_count and stall_count outputs.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'd100,
   parameter logic [XLEN-1:0] PC_LAST  = 32'd252
) (
   input  logic         clk,
   input  logic         rst,
   fetch_stage_if.slave bus
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_halted;

   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_target;
   logic            w_issue;
   logic            w_flush;
   logic            w_hold;

   assign w_pc4    = pc_plus4(r_pc);
   assign w_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

   // IDLE ignores stall/redirect entirely; elsewhere redirect beats stall.
   assign w_flush = (r_state != IDLE) && bus.redirect;
   assign w_hold  = (r_state == IDLE) || (!bus.redirect && bus.stall);
   assign w_issue = (r_state == RUN) && !bus.redirect && !bus.stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_pc     <= RESET_PC;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) r_state <= RUN;
            end
            RUN: begin
               if (bus.redirect) begin
                  r_pc <= w_target;
               end else if (!bus.stall) begin
                  // PC parks on PC_LAST so a later redirect is the only way out.
                  if (r_pc == PC_LAST) begin
                     r_state  <= HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc <= w_pc4;
                  end
               end
            end
            HALT: begin
               if (bus.redirect) begin
                  r_state  <= RUN;
                  r_halted <= 1'b0;
                  r_pc     <= w_target;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_pc = r_pc;
   assign bus.halted  = r_halted;

   ifid_reg u_ifid_reg (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_hold  (w_hold),
      .i_load  (w_issue),
      .i_inst  (bus.imem_inst),
      .i_pc4   (w_pc4),
      .o_valid (bus.ifid_valid),
      .o_inst  (bus.ifid_inst),
      .o_pc4   (bus.ifid_pc4)
   );

`ifdef FETCH_PERF_EN
   logic [XLEN-1:0] r_fetch_count;
   logic [XLEN-1:0] r_stall_count;
   logic            w_run_stall;

   assign w_run_stall = (r_state == RUN) && bus.stall && !bus.redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_issue && (r_fetch_count != '1)) r_fetch_count <= r_fetch_count + 32'd1;
         if (w_run_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign bus.fetch_count = r_fetch_count;
   assign bus.stall_count = r_stall_count;
`endif

endmodule
